// File: rtl/multi_sensor_pkg.sv
// Shared types and constants for the multi-sensor measurement/frame transmitter.
// Holds the FSM state encoding, ASCII defaults and a width helper.
package multi_sensor_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    DISPARA    = 4'd1,
    ESPERA     = 4'd2,
    PREPARA    = 4'd3,
    TRANSMITE  = 4'd4,
    AGUARDA_TX = 4'd5,
    PROXIMO    = 4'd6,
    FIM        = 4'd7
  } estado_t;

  localparam logic [2:0] DIGIT_PREFIX = 3'b011;
  localparam logic [6:0] SEP_DEFAULT  = 7'h2C;
  localparam logic [6:0] TERM_DEFAULT = 7'h23;
  localparam logic [6:0] ERR_DEFAULT  = 7'h3F;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with async reset, sync clear and enable.
// fim is high while the count sits at M-1; the next enabled cycle wraps to 0.
module contador_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = 7
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (zera_s) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == N'(M - 1)) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) q_q <= '0;
    else         q_q <= q_d;
  end

  assign fim = (q_q == N'(M - 1));

endmodule

// File: rtl/frame_char_sel.sv
// Combinational character selector: maps channel/char index plus captured
// BCD data to the ASCII character of the outgoing frame.
module frame_char_sel
  import multi_sensor_pkg::*;
#(
  parameter int unsigned NUM_SENS  = 3,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned CW        = 2,
  parameter logic [6:0]  SEP_CHAR  = SEP_DEFAULT,
  parameter logic [6:0]  TERM_CHAR = TERM_DEFAULT,
  parameter logic [6:0]  ERR_CHAR  = ERR_DEFAULT
) (
  input  logic [2:0]                     canal,
  input  logic [CW-1:0]                  indice,
  input  logic [NUM_SENS*DIGITS*4-1:0]   captura,
  input  logic [NUM_SENS-1:0]            valido,
  output logic [6:0]                     caractere
);

  logic [3:0] nib;
  logic       ok;

  always_comb begin
    nib       = '0;
    ok        = 1'b0;
    caractere = ERR_CHAR;
    // indice 0 is the most significant digit of the channel
    for (int unsigned c = 0; c < NUM_SENS; c++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (canal == 3'(c) && indice == CW'(DIGITS - 1 - d)) begin
          nib = captura[(c*DIGITS + d)*4 +: 4];
          ok  = valido[c];
        end
      end
    end
    if (indice >= CW'(DIGITS)) begin
      caractere = (canal == 3'(NUM_SENS - 1)) ? TERM_CHAR : SEP_CHAR;
    end else if (ok && nib <= 4'd9) begin
      caractere = {DIGIT_PREFIX, nib};
    end
  end

endmodule

// File: rtl/multi_sensor_frame_tx.sv
// Periodic multi-channel measurement scheduler and ASCII frame streamer
// feeding a 7E1 serial transmitter through a start/ready handshake.
module multi_sensor_frame_tx
  import multi_sensor_pkg::*;
#(
  parameter int unsigned NUM_SENS  = 3,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned PERIOD    = 50_000_000,
  parameter int unsigned TIMEOUT   = 2_500_000,
  parameter logic [6:0]  SEP_CHAR  = SEP_DEFAULT,
  parameter logic [6:0]  TERM_CHAR = TERM_DEFAULT,
  parameter logic [6:0]  ERR_CHAR  = ERR_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           ligar,
  input  logic [NUM_SENS*DIGITS*4-1:0]   medida,
  input  logic [NUM_SENS-1:0]            sens_pronto,
  input  logic                           tx_pronto,
  output logic                           medir,
  output logic                           tx_partida,
  output logic [6:0]                     tx_dados,
  output logic                           frame_done,
  output logic [NUM_SENS-1:0]            timeout_flags,
  output logic                           overrun,
  output logic [3:0]                     db_estado,
  output logic [2:0]                     db_canal
);

  localparam int unsigned MW = NUM_SENS * DIGITS * 4;
  localparam int unsigned TW = clog2(TIMEOUT);
  localparam int unsigned CW = clog2(DIGITS + 1);

  estado_t               estado_q, estado_d;
  logic                  ligar_q;
  logic [NUM_SENS-1:0]   valid_q, valid_d;
  logic [MW-1:0]         cap_q, cap_d;
  logic [TW-1:0]         to_q, to_d;
  logic [2:0]            ch_q, ch_d;
  logic [CW-1:0]         ci_q, ci_d;
  logic [6:0]            dados_q, dados_d;
  logic [NUM_SENS-1:0]   flags_q, flags_d;
  logic                  overrun_q, overrun_d;
  logic                  fim_periodo, tick;
  logic [6:0]            char_next;
  logic                  ultimo_char;

  contador_m #(
    .M (PERIOD),
    .N (clog2(PERIOD))
  ) u_periodo (
    .clock   (clock),
    .zera_as (reset),
    .zera_s  (~ligar),
    .conta   (ligar),
    .fim     (fim_periodo)
  );

  assign tick        = fim_periodo & ligar;
  assign ultimo_char = (ci_q == CW'(DIGITS)) && (ch_q == 3'(NUM_SENS - 1));

  // Channel/char position for the next cycle; drives the selector so the
  // character is already registered when tx_partida is raised.
  always_comb begin
    ch_d = ch_q;
    ci_d = ci_q;
    if (estado_q == PREPARA) begin
      ch_d = '0;
      ci_d = '0;
    end else if (estado_q == PROXIMO && !ultimo_char) begin
      if (ci_q == CW'(DIGITS)) begin
        ch_d = ch_q + 3'd1;
        ci_d = '0;
      end else begin
        ci_d = ci_q + CW'(1);
      end
    end
  end

  frame_char_sel #(
    .NUM_SENS  (NUM_SENS),
    .DIGITS    (DIGITS),
    .CW        (CW),
    .SEP_CHAR  (SEP_CHAR),
    .TERM_CHAR (TERM_CHAR),
    .ERR_CHAR  (ERR_CHAR)
  ) u_char_sel (
    .canal     (ch_d),
    .indice    (ci_d),
    .captura   (cap_q),
    .valido    (valid_q),
    .caractere (char_next)
  );

  always_comb begin
    estado_d  = estado_q;
    valid_d   = valid_q;
    cap_d     = cap_q;
    to_d      = to_q;
    flags_d   = flags_q;
    overrun_d = overrun_q;
    if (tick && estado_q != IDLE) overrun_d = 1'b1;
    unique case (estado_q)
      IDLE:       if (ligar && (!ligar_q || tick)) estado_d = DISPARA;
      DISPARA: begin
        valid_d  = '0;
        to_d     = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        for (int unsigned i = 0; i < NUM_SENS; i++) begin
          if (sens_pronto[i] && !valid_q[i]) begin
            cap_d[i*DIGITS*4 +: DIGITS*4] = medida[i*DIGITS*4 +: DIGITS*4];
            valid_d[i] = 1'b1;
          end
        end
        if (&valid_q || to_q == TW'(TIMEOUT - 1)) begin
          flags_d  = ~valid_d;
          estado_d = PREPARA;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      PREPARA:    estado_d = TRANSMITE;
      TRANSMITE:  estado_d = AGUARDA_TX;
      AGUARDA_TX: if (tx_pronto) estado_d = PROXIMO;
      PROXIMO:    estado_d = ultimo_char ? FIM : TRANSMITE;
      FIM:        estado_d = IDLE;
      default:    estado_d = IDLE;
    endcase
  end

  always_comb begin
    dados_d = dados_q;
    if (estado_d == TRANSMITE && estado_q != TRANSMITE) dados_d = char_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= IDLE;
      ligar_q   <= 1'b0;
      valid_q   <= '0;
      cap_q     <= '0;
      to_q      <= '0;
      ch_q      <= '0;
      ci_q      <= '0;
      dados_q   <= '0;
      flags_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      ligar_q   <= ligar;
      valid_q   <= valid_d;
      cap_q     <= cap_d;
      to_q      <= to_d;
      ch_q      <= ch_d;
      ci_q      <= ci_d;
      dados_q   <= dados_d;
      flags_q   <= flags_d;
      overrun_q <= overrun_d;
    end
  end

  assign medir         = (estado_q == DISPARA);
  assign tx_partida    = (estado_q == TRANSMITE);
  assign frame_done    = (estado_q == FIM);
  assign tx_dados      = dados_q;
  assign timeout_flags = flags_q;
  assign overrun       = overrun_q;
  assign db_estado     = estado_q;
  assign db_canal      = ch_q;

endmodule

// File: doc/multi_sensor_frame_tx.md
Name: multi_sensor_frame_tx

Overview:
Parametrised successor to the fixed three-sensor measurement/serial datapath. It schedules periodic measurements on NUM_SENS ultrasonic channels and captures each channel's BCD result, with a per-channel timeout. It then streams one ASCII frame per period to an external 7E1 serial transmitter through a start/ready handshake. It sits between the N interface_hcsr04 instances and a single tx_serial_7E1, and replaces the hand-wired mux trees and the external counters.

Parameters:
NUM_SENS, 3, number of sensor channels (1..8)
DIGITS, 3, BCD digits per measurement (1..4)
PERIOD, 50_000_000, clock cycles between measurement cycles
TIMEOUT, 2_500_000, maximum cycles to wait for all sensors after medir
SEP_CHAR, 7'h2C, separator sent after every channel except the last (',')
TERM_CHAR, 7'h23, frame terminator ('#')
ERR_CHAR, 7'h3F, digit substitute for timed-out channel or non-BCD nibble ('?')

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ligar  in  1  enable periodic operation (level)
medida  in  NUM_SENS*DIGITS*4  concatenated BCD results; channel 0 in LSBs
sens_pronto  in  NUM_SENS  per-channel measurement-done pulse
tx_pronto  in  1  transmitter finished current character (1-cycle pulse)
medir  out  1  one-cycle pulse to all sensor interfaces
tx_partida  out  1  one-cycle start pulse to transmitter
tx_dados  out  7  ASCII character to transmit
frame_done  out  1  one-cycle pulse after terminator accepted
timeout_flags  out  NUM_SENS  channels that timed out in last cycle
overrun  out  1  sticky: period tick arrived while frame busy
db_estado  out  4  current FSM state encoding
db_canal  out  3  channel index being transmitted

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0, tx_dados=7'h00. Period/timeout/char counters 0. Capture registers and valid bits cleared.
- Period counter runs only while ligar=1; cleared while ligar=0. tick asserts when count==PERIOD-1, and the count then wraps to 0.
- ligar rising edge (IDLE) starts a cycle immediately, without waiting for tick.
- States: IDLE(0), DISPARA(1), ESPERA(2), PREPARA(3), TRANSMITE(4), AGUARDA_TX(5), PROXIMO(6), FIM(7).
- IDLE -> DISPARA on ligar rise or (ligar & tick).
- DISPARA: medir=1 for exactly one cycle; clear valid bits and timeout counter -> ESPERA.
- ESPERA:
  - sens_pronto[i]=1 latches medida slice i and sets valid[i]. The first pronto wins; later pulses are ignored.
  - -> PREPARA when all valid, or when the timeout counter reaches TIMEOUT-1.
  - On exit, timeout_flags <= ~valid.
- PREPARA: channel=0, char index=0 -> TRANSMITE.
- TRANSMITE:
  - tx_dados <= current char; tx_partida=1 for one cycle -> AGUARDA_TX.
  - Char order per channel: DIGITS digits MSB first, then SEP_CHAR, or TERM_CHAR for the last channel.
  - Frame length is NUM_SENS*(DIGITS+1).
- Digit encoding: {3'b011, nibble} if valid and nibble<=9, else ERR_CHAR.
- AGUARDA_TX: tx_dados held stable; wait for tx_pronto. tx_pronto in any other state is ignored.
- On tx_pronto:
  - -> PROXIMO.
  - PROXIMO advances char index; on the last char of a channel, advance channel. After the terminator -> FIM, otherwise -> TRANSMITE.
- FIM: frame_done=1 for one cycle -> IDLE. If ligar=0, stay IDLE.
- tick while not IDLE: no new cycle starts; overrun set (sticky until reset).
- ligar deasserted mid-cycle: current frame completes, then IDLE.
- sens_pronto outside ESPERA is ignored and does not alter captured data.
- Latency: medir to first tx_partida = sensor completion + 3 cycles.

Decomposition:
- Package multi_sensor_pkg holds:
  - state encoding localparams;
  - ASCII constants (digit prefix 3'b011, default SEP/TERM/ERR);
  - width helper function clog2.
- One sub-module, frame_char_sel: a combinational block that maps (channel, char index, capture regs, valid) to the 7-bit char.
- Reuse the existing contador_m for the period counter.

Test Plan:
- PERIOD=200, TIMEOUT=50, NUM_SENS=3, DIGITS=3, transmitter model returns tx_pronto 10 cycles after start; medida ch0=0x123, ch1=0x045, ch2=0x999, all pronto 5 cycles after medir -> frame "123,045,999#" (12 chars), one frame_done, timeout_flags=000.
- Same, ch1 never pulses pronto -> after 50 cycles frame "123,???,999#", timeout_flags=010.
- ch0=0x1A3 -> "1?3,…" ('?' for non-BCD nibble).
- Period tick while AGUARDA_TX (slow transmitter, 30 cycles/char) -> no medir during frame, overrun=1.
- Reset asserted in AGUARDA_TX -> all outputs 0 in the same cycle, db_estado=0; after release with ligar=1 a fresh frame starts with medir.
- ligar dropped mid-frame -> remaining chars sent, frame_done, then no further medir.
